axis_packetizer: RTL and testbench

Downstream framing stage for the double-bank AXI-Stream FIFO. It consumes the FIFO's master stream and regenerates frame boundaries: it forwards every beat unchanged and asserts `m_tlast` on every `FRAME_LEN`-th beat. An upstream `s_tlast` that arrives early is honoured as a truncated frame and counted. A two-entry registered skid buffer decouples `s_tready` from `m_tready` and sustains full throughput.

---
 rtl/axis_packetizer.sv | 100 ++++++++++
 tb/tb_axis_packetizer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packetizer.sv
// axis_packetizer: re-frames an AXI-Stream by tagging every FRAME_LEN-th
// beat (or an early s_tlast) with m_tlast, through a 2-entry skid buffer.
// Ports:
//   clk, rst                 clock, async active-high reset
//   s_tdata/tvalid/tlast     upstream beat, s_tready registered
//   m_tdata/tvalid/tlast     downstream beat (registered), m_tready in
//   frame_cnt                frames sent, wraps
//   early_err_cnt            frames cut by early s_tlast, saturates
module axis_packetizer #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 4096
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic [15:0]   frame_cnt,
  output logic [15:0]   early_err_cnt
);

  localparam int CW = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  logic [CW-1:0] beat_idx;
  logic [DW-1:0] skid_data;
  logic          skid_last;
  logic          skid_vld;

  logic accept;
  logic send;
  logic out_free;
  logic at_end;
  logic tag_last;
  logic early;
  logic skid_nxt;

  assign accept   = s_tvalid && s_tready;
  assign send     = m_tvalid && m_tready;
  assign out_free = !m_tvalid || m_tready;
  assign at_end   = (beat_idx == LAST_IDX);
  assign tag_last = at_end || s_tlast;
  assign early    = accept && s_tlast && !at_end;

  // Skid holds a beat only while the output register cannot take one.
  // s_tready is its registered inverse, so no path from m_tready.
  assign skid_nxt = skid_vld ? !out_free : (accept && !out_free);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tdata       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      s_tready      <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
      skid_vld      <= 1'b0;
      beat_idx      <= '0;
      frame_cnt     <= '0;
      early_err_cnt <= '0;
    end else begin
      if (out_free) begin
        if (skid_vld) begin
          m_tdata  <= skid_data;
          m_tlast  <= skid_last;
          m_tvalid <= 1'b1;
        end else if (accept) begin
          m_tdata  <= s_tdata;
          m_tlast  <= tag_last;
          m_tvalid <= 1'b1;
        end else begin
          m_tvalid <= 1'b0;
        end
      end else if (accept) begin
        skid_data <= s_tdata;
        skid_last <= tag_last;
      end
      skid_vld <= skid_nxt;
      s_tready <= !skid_nxt;

      if (accept) begin
        beat_idx <= tag_last ? '0 : beat_idx + CW'(1);
      end

      if (send && m_tlast) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      if (early && early_err_cnt != 16'hFFFF) begin
        early_err_cnt <= early_err_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// tb_axis_packetizer: directed stream tests with a queue-based reference
// model checked every cycle, plus literal expectations per scenario.
module tb_axis_packetizer;

  localparam int DW = 16;
  localparam int FL = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready = 1'b1;
  logic [15:0]   frame_cnt;
  logic [15:0]   early_err_cnt;

  axis_packetizer #(.DW(DW), .FRAME_LEN(FL)) dut (
    .clk(clk),
    .rst(rst),
    .s_tdata(s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast(s_tlast),
    .s_tready(s_tready),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast(m_tlast),
    .m_tready(m_tready),
    .frame_cnt(frame_cnt),
    .early_err_cnt(early_err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // reference model state
  logic [DW:0] q[$];
  int          pos = 0;
  logic [15:0] mf = '0;
  logic [15:0] me = '0;
  int          cyc = 0;
  bit          prev_rst = 1'b1;
  bit          prev_hold = 1'b0;
  logic [DW-1:0] hd;
  logic          hl;

  // per-segment observations
  int          seg_sent = 0;
  int          last_pos[$];
  int          first_acc = -1;
  int          first_vld = -1;
  int          first_send = -1;
  int          last_send = -1;
  logic [DW-1:0] first_data;

  int bp = 0;

  always @(negedge clk) begin
    logic [DW:0] e;
    logic        el;
    bit          acc;
    bit          snd;
    if (rst) begin
      q.delete();
      pos = 0;
      mf = '0;
      me = '0;
      prev_rst = 1'b1;
      prev_hold = 1'b0;
    end else begin
      acc = s_tvalid && s_tready;
      snd = m_tvalid && m_tready;
      chk("m_tvalid_occ", 32'(m_tvalid), 32'(q.size() > 0));
      if (!prev_rst)
        chk("s_tready_occ", 32'(s_tready), 32'(q.size() < 2));
      chk("frame_cnt", 32'(frame_cnt), 32'(mf));
      chk("early_err_cnt", 32'(early_err_cnt), 32'(me));
      if (prev_hold) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", 32'(m_tdata), 32'(hd));
        chk("hold_last", 32'(m_tlast), 32'(hl));
      end
      if (snd) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(m_tdata), 32'hFFFFFFFF);
        end else begin
          e = q.pop_front();
          chk("m_tdata", 32'(m_tdata), 32'(e[DW-1:0]));
          chk("m_tlast", 32'(m_tlast), 32'(e[DW]));
          if (e[DW]) mf = mf + 16'd1;
        end
        if (seg_sent == 0) begin
          first_send = cyc;
          first_data = m_tdata;
        end
        last_send = cyc;
        seg_sent++;
        if (m_tlast) last_pos.push_back(seg_sent);
      end
      if (acc) begin
        el = (pos == FL - 1) || s_tlast;
        if (s_tlast && pos != FL - 1 && me != 16'hFFFF) me = me + 16'd1;
        q.push_back({el, s_tdata});
        pos = el ? 0 : pos + 1;
        if (first_acc < 0) first_acc = cyc;
      end
      if (first_vld < 0 && m_tvalid) first_vld = cyc;
      prev_hold = m_tvalid && !m_tready;
      hd = m_tdata;
      hl = m_tlast;
      prev_rst = 1'b0;
    end
    cyc++;
  end

  // downstream ready pattern
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (bp)
        0: m_tready = 1'b1;
        1: m_tready = ((cyc / 256) % 2 == 1) ? !m_tready
                                             : 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic seg_clear();
    seg_sent = 0;
    last_pos.delete();
    first_acc = -1;
    first_vld = -1;
    first_send = -1;
    last_send = -1;
  endtask

  task automatic send_beats(int n, int base, int tl_at);
    int t;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata = DW'(base + i);
      s_tlast = (i + 1 == tl_at);
      t = 0;
      while (!s_tready && t < 1000) begin
        step();
        t++;
      end
      if (t >= 1000) begin
        chk("accept_timeout", 32'(t), 32'd0);
        s_tvalid = 1'b0;
        return;
      end
      step();
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bp = 0;
    while ((q.size() != 0 || m_tvalid) && t < 2000) begin
      step();
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 32'(t), 32'd0);
    step();
  endtask

  task automatic chk_lasts(string nm, int a, int b);
    int n = (b > 0) ? 2 : 1;
    chk({nm, "_count"}, 32'(last_pos.size()), 32'(n));
    if (last_pos.size() == n) begin
      chk({nm, "_first"}, 32'(last_pos[0]), 32'(a));
      if (n == 2) chk({nm, "_second"}, 32'(last_pos[1]), 32'(b));
    end
  endtask

  initial begin
    // reset values appear before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_early_cnt", 32'(early_err_cnt), 32'd0);
    step();
    step();
    rst = 1'b0;
    #1 chk("rel_s_tready_pre", 32'(s_tready), 32'd0);
    step();
    chk("rel_s_tready_post", 32'(s_tready), 32'd1);

    // continuous frames
    seg_clear();
    send_beats(8192, 1, 0);
    drain();
    chk_lasts("cont_lasts", 4096, 8192);
    chk("cont_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("cont_latency", 32'(first_vld - first_acc), 32'd1);
    chk("cont_span", 32'(last_send - first_send + 1), 32'd8192);
    chk("cont_sent", 32'(seg_sent), 32'd8192);

    // random and alternating backpressure
    seg_clear();
    bp = 1;
    send_beats(8192, 1, 0);
    drain();
    chk_lasts("bp_lasts", 4096, 8192);
    chk("bp_sent", 32'(seg_sent), 32'd8192);
    chk("bp_frame_cnt", 32'(frame_cnt), 32'd4);

    // early s_tlast on beat 100
    seg_clear();
    send_beats(4196, 20001, 100);
    drain();
    chk_lasts("early_lasts", 100, 4196);
    chk("early_err", 32'(early_err_cnt), 32'd1);
    chk("early_frame_cnt", 32'(frame_cnt), 32'd6);

    // on-time s_tlast on beat 4096
    seg_clear();
    send_beats(4096, 30001, 4096);
    drain();
    chk_lasts("ontime_lasts", 4096, 0);
    chk("ontime_err", 32'(early_err_cnt), 32'd1);
    chk("ontime_frame_cnt", 32'(frame_cnt), 32'd7);

    // mid-frame reset with both registers occupied
    seg_clear();
    send_beats(1000, 40001, 0);
    bp = 2;
    s_tvalid = 1'b1;
    s_tdata = 16'd41001;
    step();
    s_tdata = 16'd41002;
    step();
    step();
    chk("pre_rst_full", 32'(s_tready), 32'd0);
    #3 rst = 1'b1;
    #1;
    chk("mid_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("mid_m_tdata", 32'(m_tdata), 32'd0);
    chk("mid_s_tready", 32'(s_tready), 32'd0);
    chk("mid_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_early_cnt", 32'(early_err_cnt), 32'd0);
    s_tvalid = 1'b0;
    bp = 0;
    step();
    step();
    rst = 1'b0;
    #1 chk("mid_rel_pre", 32'(s_tready), 32'd0);
    step();
    chk("mid_rel_post", 32'(s_tready), 32'd1);
    seg_clear();
    send_beats(4096, 50001, 0);
    drain();
    chk("post_first_data", 32'(first_data), 32'd50001);
    chk_lasts("post_lasts", 4096, 0);
    chk("post_sent", 32'(seg_sent), 32'd4096);
    chk("post_frame_cnt", 32'(frame_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
